// File: rtl/pc_next_seq_if.sv
// Handshake bundle between the PC register/pipeline and the next-PC sequencer.
// Master drives the current PC and redirect requests; slave returns the next PC and status.
interface pc_next_seq_if #(
  parameter int WIDTH = 12
);
  logic [WIDTH-1:0] pc_q;
  logic             stall;
  logic             branch_taken;
  logic [15:0]      branch_off;
  logic             jump;
  logic [25:0]      jump_idx;
  logic             jr;
  logic [31:0]      jr_addr;
  logic             exception;
  logic             halt_req;
  logic             resume;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_plus1;
  logic             flush_ifid;
  logic             pend_valid;
  logic             halted;

  modport master (
    output pc_q, stall, branch_taken, branch_off, jump, jump_idx,
           jr, jr_addr, exception, halt_req, resume,
    input  pc_d, pc_plus1, flush_ifid, pend_valid, halted
  );

  modport slave (
    input  pc_q, stall, branch_taken, branch_off, jump, jump_idx,
           jr, jr_addr, exception, halt_req, resume,
    output pc_d, pc_plus1, flush_ifid, pend_valid, halted
  );
endinterface

// File: rtl/pc_next_seq.sv
// Next-PC sequencer feeding the d input of a PC register that has no write enable.
// Arbitrates sequential fetch and redirects, holds on stall/halt, replays stalled redirects.
//
// state | meaning
// RUN   | normal fetch; redirects applied immediately unless stalled
// PEND  | a redirect arrived under stall; r_pend_tgt replays when stall drops
// HALT  | PC held until resume or exception
module pc_next_seq #(
  parameter int               WIDTH      = 12,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 12'h010
) (
  input  logic             clk,
  input  logic             clr,
  pc_next_seq_if.slave     s_if
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PEND = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_pend_tgt;
  logic [WIDTH-1:0] w_pend_tgt_nxt;

  logic [WIDTH-1:0] w_plus1;
  logic [WIDTH-1:0] w_br_tgt;
  logic [WIDTH-1:0] w_tgt;
  logic             w_redir;
  logic [WIDTH-1:0] w_pc_d;
  logic             w_flush;
  logic             w_unused;

  // Offset is truncated to WIDTH, so sign extension is implicit in the modular add.
  assign w_plus1  = s_if.pc_q + 1'b1;
  assign w_br_tgt = w_plus1 + s_if.branch_off[WIDTH-1:0];
  assign w_redir  = s_if.jr | s_if.jump | s_if.branch_taken;
  assign w_unused = ^{s_if.branch_off[15:WIDTH], s_if.jump_idx[25:WIDTH],
                      s_if.jr_addr[31:WIDTH]};

  always_comb begin
    if (s_if.jr)
      w_tgt = s_if.jr_addr[WIDTH-1:0];
    else if (s_if.jump)
      w_tgt = s_if.jump_idx[WIDTH-1:0];
    else
      w_tgt = w_br_tgt;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state    <= RUN;
      r_pend_tgt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pend_tgt <= w_pend_tgt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pend_tgt_nxt = r_pend_tgt;
    w_pc_d         = w_plus1;
    w_flush        = 1'b0;
    case (r_state)
      RUN: begin
        if (s_if.exception) begin
          w_pc_d  = EXC_VECTOR;
          w_flush = 1'b1;
        end else if (s_if.stall && w_redir) begin
          w_pc_d         = s_if.pc_q;
          w_pend_tgt_nxt = w_tgt;
          w_state_nxt    = PEND;
        end else if (s_if.stall) begin
          w_pc_d = s_if.pc_q;
        end else if (w_redir) begin
          w_pc_d  = w_tgt;
          w_flush = 1'b1;
        end else if (s_if.halt_req) begin
          w_pc_d      = s_if.pc_q;
          w_state_nxt = HALT;
        end
      end
      // Newer redirects under stall are dropped: the latched one is architecturally first.
      PEND: begin
        if (s_if.exception) begin
          w_pc_d      = EXC_VECTOR;
          w_flush     = 1'b1;
          w_state_nxt = RUN;
        end else if (s_if.stall) begin
          w_pc_d = s_if.pc_q;
        end else begin
          w_pc_d      = r_pend_tgt;
          w_flush     = 1'b1;
          w_state_nxt = RUN;
        end
      end
      HALT: begin
        if (s_if.exception) begin
          w_pc_d      = EXC_VECTOR;
          w_flush     = 1'b1;
          w_state_nxt = RUN;
        end else begin
          w_pc_d = s_if.pc_q;
          if (s_if.resume)
            w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  assign s_if.pc_d       = w_pc_d;
  assign s_if.pc_plus1   = w_plus1;
  assign s_if.flush_ifid = w_flush;
  assign s_if.pend_valid = (r_state == PEND);
  assign s_if.halted     = (r_state == HALT);

endmodule

// File: tb/tb_pc_next_seq.sv
// Self-checking bench for pc_next_seq: directed vector table, hand-written sequences,
// and randomized traffic against a flag-based behavioural model of the sequencer.
module tb_pc_next_seq;
  localparam int W = 12;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  pc_next_seq_if #(.WIDTH(W)) bus ();

  pc_next_seq #(.WIDTH(W), .EXC_VECTOR(12'h010)) dut (
    .clk  (clk),
    .clr  (clr),
    .s_if (bus.slave)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: PC as an integer, plus "pending" / "halted" flags and the saved target.
  bit m_pend;
  bit m_halt;
  int m_tgt;
  int m_pc;

  typedef struct {
    logic [11:0] pc;
    logic        stall;
    logic        br;
    logic [15:0] off;
    logic        jmp;
    logic [25:0] idx;
    logic        jr;
    logic [31:0] jra;
    logic        exc;
    logic [11:0] exp_d;
    logic        exp_f;
  } vec_t;

  vec_t tbl[12];

  function automatic int wrap(int x);
    return x & 32'hFFF;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_eval(output int d, output bit f, output bit np,
                            output bit nh, output int nt);
    int p1;
    int t;
    bit rd;
    p1 = wrap(m_pc + 1);
    rd = bus.jr | bus.jump | bus.branch_taken;
    if (bus.jr)        t = int'(bus.jr_addr) & 32'hFFF;
    else if (bus.jump) t = int'(bus.jump_idx) & 32'hFFF;
    else               t = wrap(p1 + int'($signed(bus.branch_off)));
    d = p1; f = 0; np = m_pend; nh = m_halt; nt = m_tgt;
    if (m_halt) begin
      if (bus.exception) begin d = 16; f = 1; nh = 0; end
      else begin d = m_pc; if (bus.resume) nh = 0; end
    end else if (m_pend) begin
      if (bus.exception)  begin d = 16; f = 1; np = 0; end
      else if (bus.stall) d = m_pc;
      else begin d = m_tgt; f = 1; np = 0; end
    end else begin
      if (bus.exception)           begin d = 16; f = 1; end
      else if (bus.stall && rd)    begin d = m_pc; np = 1; nt = t; end
      else if (bus.stall)          d = m_pc;
      else if (rd)                 begin d = t; f = 1; end
      else if (bus.halt_req)       begin d = m_pc; nh = 1; end
    end
  endtask

  task automatic set_pc(int pc);
    m_pc = wrap(pc);
    bus.pc_q = W'(m_pc);
  endtask

  task automatic set_idle();
    bus.stall = 0; bus.branch_taken = 0; bus.branch_off = '0;
    bus.jump = 0; bus.jump_idx = '0; bus.jr = 0; bus.jr_addr = '0;
    bus.exception = 0; bus.halt_req = 0; bus.resume = 0;
  endtask

  // Compare everything at the falling edge, then advance the model and the PC register.
  task automatic step();
    int d;
    int nt;
    bit f;
    bit np;
    bit nh;
    @(negedge clk);
    model_eval(d, f, np, nh, nt);
    chk("pc_d",       int'(bus.pc_d),       d);
    chk("flush_ifid", int'(bus.flush_ifid), int'(f));
    chk("pc_plus1",   int'(bus.pc_plus1),   wrap(m_pc + 1));
    chk("pend_valid", int'(bus.pend_valid), int'(m_pend));
    chk("halted",     int'(bus.halted),     int'(m_halt));
    @(posedge clk);
    if (clr) begin
      m_pend = 0; m_halt = 0; m_tgt = 0;
    end else begin
      m_pend = np; m_halt = nh; m_tgt = nt;
    end
    m_pc = d;
    #1 bus.pc_q = W'(m_pc);
  endtask

  initial begin
    tbl[0]  = '{12'd0,    0, 0, 16'h0000, 0, 26'h0,       0, 32'h0,          0, 12'd1,    0};
    tbl[1]  = '{12'd4095, 0, 0, 16'h0000, 0, 26'h0,       0, 32'h0,          0, 12'd0,    0};
    tbl[2]  = '{12'd100,  0, 1, 16'hFFF6, 0, 26'h0,       0, 32'h0,          0, 12'd91,   1};
    tbl[3]  = '{12'd100,  0, 1, 16'hFFF6, 1, 26'h0000200, 0, 32'h0,          0, 12'd512,  1};
    tbl[4]  = '{12'd100,  0, 1, 16'hFFF6, 1, 26'h0000200, 1, 32'h0000ABCD,   0, 12'hBCD,  1};
    tbl[5]  = '{12'd4095, 0, 1, 16'h0005, 0, 26'h0,       0, 32'h0,          0, 12'd5,    1};
    tbl[6]  = '{12'd10,   0, 1, 16'h8000, 0, 26'h0,       0, 32'h0,          0, 12'd11,   1};
    tbl[7]  = '{12'd10,   0, 1, 16'h0FFF, 0, 26'h0,       0, 32'h0,          0, 12'd10,   1};
    tbl[8]  = '{12'd50,   0, 0, 16'h0000, 0, 26'h0,       1, 32'h00000123,   1, 12'h010,  1};
    tbl[9]  = '{12'd50,   0, 0, 16'h0000, 1, 26'h3FFFFFF, 0, 32'h0,          0, 12'hFFF,  1};
    tbl[10] = '{12'd33,   1, 0, 16'h0000, 0, 26'h0,       0, 32'h0,          0, 12'd33,   0};
    tbl[11] = '{12'd2000, 0, 0, 16'h0000, 0, 26'h0,       1, 32'hFFFFF001,   0, 12'h001,  1};

    m_pend = 0; m_halt = 0; m_tgt = 0;
    clr = 1'b1;
    set_idle();
    set_pc(0);
    #2;
    chk("rst_pc_d",       int'(bus.pc_d),       1);
    chk("rst_pend_valid", int'(bus.pend_valid), 0);
    chk("rst_halted",     int'(bus.halted),     0);
    #10 clr = 1'b0;

    // Closed-loop idle fetch: pc_q walks 0,1,2,3,4,5.
    for (int i = 0; i < 6; i++) step();
    chk("seq_pc_after_6", int'(bus.pc_q), 6);
    set_pc(4095);
    step();

    // Directed vector table (all in RUN, none of them change state).
    for (int i = 0; i < 12; i++) begin
      bus.stall = tbl[i].stall; bus.branch_taken = tbl[i].br; bus.branch_off = tbl[i].off;
      bus.jump = tbl[i].jmp; bus.jump_idx = tbl[i].idx; bus.jr = tbl[i].jr;
      bus.jr_addr = tbl[i].jra; bus.exception = tbl[i].exc;
      set_pc(int'(tbl[i].pc));
      #1;
      chk($sformatf("vec%0d_pc_d", i),  int'(bus.pc_d),       int'(tbl[i].exp_d));
      chk($sformatf("vec%0d_flush", i), int'(bus.flush_ifid), int'(tbl[i].exp_f));
      step();
    end
    set_idle();

    // Stalled jump is latched, held through a stalled branch, then replayed.
    set_pc(40);
    bus.stall = 1; bus.jump = 1; bus.jump_idx = 26'd300;
    step();
    bus.jump = 0;
    for (int i = 0; i < 3; i++) begin
      bus.branch_taken = (i != 1); bus.branch_off = 16'h0005;
      step();
    end
    bus.branch_taken = 0; bus.stall = 0;
    #1;
    chk("pend_replay_pc_d",  int'(bus.pc_d),       300);
    chk("pend_replay_flush", int'(bus.flush_ifid), 1);
    step();
    step();

    // Exception while pending discards the latched redirect.
    bus.stall = 1; bus.jump = 1; bus.jump_idx = 26'd300;
    step();
    bus.jump = 0; bus.exception = 1;
    #1;
    chk("pend_exc_pc_d", int'(bus.pc_d), 16);
    step();
    set_idle();
    step();

    // Halt holds PC even with a jump asserted, resume restarts with pc+1.
    set_pc(7);
    bus.halt_req = 1;
    step();
    bus.halt_req = 0; bus.jump = 1; bus.jump_idx = 26'd99;
    for (int i = 0; i < 4; i++) step();
    bus.jump = 0; bus.resume = 1;
    step();
    bus.resume = 0;
    #1;
    chk("resume_pc_d", int'(bus.pc_d), 8);
    step();

    // Asynchronous clear mid-PEND and mid-HALT drops status without a clock edge.
    bus.stall = 1; bus.jump = 1; bus.jump_idx = 26'd300;
    step();
    set_idle(); bus.stall = 1;
    #2 clr = 1'b1;
    #1;
    chk("clr_pend_valid", int'(bus.pend_valid), 0);
    chk("clr_halted",     int'(bus.halted),     0);
    m_pend = 0; m_halt = 0; m_tgt = 0;
    set_idle();
    set_pc(0);
    step();
    #2 clr = 1'b0;
    set_pc(0);
    step();
    bus.halt_req = 1;
    step();
    bus.halt_req = 0;
    #2 clr = 1'b1;
    #1;
    chk("clr_halt_halted", int'(bus.halted), 0);
    m_pend = 0; m_halt = 0; m_tgt = 0;
    step();
    #2 clr = 1'b0;
    set_pc(0);
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.stall        = ($urandom_range(0, 99) < 25);
      bus.branch_taken = ($urandom_range(0, 99) < 15);
      bus.branch_off   = 16'($urandom);
      bus.jump         = ($urandom_range(0, 99) < 8);
      bus.jump_idx     = 26'($urandom);
      bus.jr           = ($urandom_range(0, 99) < 6);
      bus.jr_addr      = $urandom;
      bus.exception    = ($urandom_range(0, 99) < 3);
      bus.halt_req     = ($urandom_range(0, 99) < 6);
      bus.resume       = ($urandom_range(0, 99) < 20);
      if ($urandom_range(0, 99) < 5) set_pc(int'($urandom_range(0, 4095)));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/pc_next_seq.md
Name: pc_next_seq

Overview:
- Next-PC sequencer that sits directly upstream of the 12-bit PC register. Its output `pc_d` is the register's `d` input; the register's `q` feeds back as `pc_q`.
- The PC register has no write enable, so this block also implements hold (stall/halt) by presenting `pc_q` back on `pc_d`.
- Arbitrates sequential fetch, branch, jump, jump-register and exception redirects.
- Latches a redirect that arrives during a stall and replays it once the stall drops.

Parameters:
- WIDTH, 12, PC width in bits (word address).
- EXC_VECTOR, 12'h010, exception handler address.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clr  in  1  asynchronous, active-high reset.
- pc_q  in  WIDTH  current PC from the PC register.
- stall  in  1  hazard stall: hold PC.
- branch_taken  in  1  conditional branch resolved taken.
- branch_off  in  16  signed word offset from the instruction immediate.
- jump  in  1  J/JAL.
- jump_idx  in  26  instruction index field.
- jr  in  1  JR.
- jr_addr  in  32  register value for JR.
- exception  in  1  exception request.
- halt_req  in  1  enter halt.
- resume  in  1  leave halt.
- pc_d  out  WIDTH  next PC to the PC register (combinational).
- pc_plus1  out  WIDTH  pc_q+1, used as the link value.
- flush_ifid  out  1  redirect applied this cycle; downstream IF/ID squashes its entry (combinational).
- pend_valid  out  1  a redirect is latched, awaiting stall release (registered).
- halted  out  1  block is in the HALT state (registered).

Behaviour:
- Arithmetic, all results truncated to WIDTH (mod 4096):
  - pc_plus1 = pc_q+1; 4095 wraps to 0.
  - Branch target = pc_plus1 + sign-extended branch_off[WIDTH-1:0].
  - Jump target = jump_idx[WIDTH-1:0].
  - JR target = jr_addr[WIDTH-1:0].
- Redirect request priority: exception > jr > jump > branch_taken. The chosen target is `tgt`; `redir` = any of the four asserted (exception is handled separately below).
- States: RUN, PEND, HALT. Registered: state, pend_tgt[WIDTH-1:0].
- RUN:
  - exception: pc_d=EXC_VECTOR, flush=1, stay RUN. Ignores stall.
  - stall & redir: pc_d=pc_q, flush=0, pend_tgt<=tgt, go PEND.
  - stall only: pc_d=pc_q.
  - redir: pc_d=tgt, flush=1.
  - halt_req, with no redir and no stall: pc_d=pc_q, go HALT.
  - otherwise: pc_d=pc_plus1.
- PEND:
  - exception: pc_d=EXC_VECTOR, flush=1, pending discarded, go RUN.
  - stall: pc_d=pc_q. Any new redir is ignored (the older redirect is architecturally first).
  - stall dropped: pc_d=pend_tgt, flush=1, go RUN.
  - halt_req is ignored in PEND.
- HALT:
  - pc_d=pc_q; stall and redir are ignored.
  - exception: pc_d=EXC_VECTOR, flush=1, go RUN.
  - resume: pc_d=pc_q, go RUN. Fetch restarts the following cycle with pc_plus1.
- pend_valid=(state==PEND); halted=(state==HALT).
- Reset (clr high, asynchronous): state=RUN, pend_tgt=0, pend_valid=0, halted=0.
  - Outputs during clr follow RUN decode of the inputs. Since the PC register clears to 0, pc_d=1 with idle inputs.
  - clr mid-PEND or mid-HALT discards pending/halt immediately, without waiting for a clock edge.
- Latency: a redirect not under stall reaches pc_q 1 cycle after assertion. A stalled redirect reaches pc_q 1 cycle after stall deasserts.

Test Plan:
- Reset then idle 5 cycles, loop pc_q<=pc_d → pc sequence 0,1,2,3,4,5; flush=0; pending/halt outputs 0. Preload pc_q=4095 → pc_d=0 (wrap).
- pc_q=100, branch_taken, branch_off=16'hFFF6 → pc_d=91, flush=1. Same cycle add jump, jump_idx=26'h0000200 → pc_d=512. Add jr, jr_addr=32'h0000ABCD → pc_d=12'hBCD.
- pc_q=40, stall=1 and jump to 300 in the same cycle → pc_d=40, pend_valid=1 next cycle. Hold stall 3 cycles with branch_taken pulsed → pc_d=40 throughout, pend_tgt stays 300. Drop stall → pc_d=300, flush=1, pend_valid=0.
- While in PEND (target 300), exception → pc_d=16, flush=1, pend_valid=0 next cycle.
- pc_q=7, halt_req → halted=1; 4 cycles with jump asserted → pc_d=7, flush=0. resume → halted=0, then pc_d=8.
- Assert clr asynchronously mid-PEND, between clock edges → pend_valid and halted drop immediately. After clr releases, with pc_q=0, sequencing restarts with pc_d=1.
